sensor_axil_regs: RTL and testbench
===================================

# sensor_axil_regs

AXI4-Lite slave register file for the sensor IP; it is the responder to the AXI4-Lite master that drives the S00_AXI port. It holds NUM_REGS 32-bit control/data registers. Write address and write data are accepted independently, byte strobes are honoured, and one write response and one read response are returned per transaction. Register contents and a per-register write pulse are exported to the sensor core.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 6, byte address width.
- NUM_REGS, 4, number of 32-bit registers at word offsets 0..NUM_REGS-1.

Ports:
- S_AXI_ACLK  in  1  single clock for the block.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- reg_q  out  NUM_REGS*32  current register contents; register k is at bits [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle register k is written.

## Operation
- Word index = ADDR[ADDR_WIDTH-1:2]. ADDR[1:0] is ignored.
- Write channel:
  - An AW holding slot and a W holding slot each capture one beat on handshake.
  - AWREADY = !aw_full && !BVALID.
  - WREADY = !w_full && !BVALID.
  - When both slots are full, or both handshakes occur in the same cycle, the write commits on the next clock edge.
  - At commit: each byte with WSTRB[b]=1 is updated, both slots clear, BVALID rises, and reg_wr_pulse[idx] fires for one cycle.
  - BVALID holds with stable BRESP until BREADY. No new AW or W is accepted while BVALID is high.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake, RDATA and RRESP are registered and RVALID rises on the next edge.
  - RVALID, RDATA and RRESP hold until RREADY.
- The read and write paths are independent. A read accepted in the same cycle as a write commit to the same register returns the pre-write value.
- WSTRB=0 still produces a response (OKAY) but changes no data and fires no pulse.
- AWPROT and ARPROT have no effect.

## Timing
- Reset (asynchronous, active-high):
  - All registers = 0.
  - AWREADY, WREADY and ARREADY = 0 while reset is high.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0; reg_wr_pulse = 0.
- The first cycle after reset deassertion:
  - AWREADY, WREADY and ARREADY = 1.
- Write latency: handshake of the last of AW/W in cycle N -> register updated and BVALID=1 at cycle N+1.
- Back-to-back throughput: one write every 2 cycles with BREADY tied high; one read every 2 cycles with RREADY tied high.
- Reset asserted mid-transaction drops any pending slot or response without completing it; no partial register update occurs.

## Configuration
- SENSOR_AXIL_SLVERR_EN defined:
  - Word index >= NUM_REGS returns SLVERR (2'b10).
  - Such writes are discarded with no reg_wr_pulse.
  - Such reads return RDATA = 0.
- SENSOR_AXIL_SLVERR_EN undefined:
  - The index is taken modulo NUM_REGS (aliasing).
  - BRESP and RRESP are always OKAY.

## Structure
- Package sensor_axil_pkg holds:
  - Response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - The strobe-merge function (old, new, strb) -> merged word.
- Sub-module sensor_axil_wr_slot: a one-entry valid/data holding register, instantiated for AW and W.
- Read path and register array stay in the top module.

## Test plan
- Sequential write/read: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read them back -> RDATA is 0x1..0x4, all responses OKAY.
- Skewed channels: W presented 3 cycles before AW, addr 0x4, data 0xDEADBEEF -> WREADY drops after the W handshake; BVALID one cycle after the AW handshake; reg_q[63:32] = 0xDEADBEEF.
- Strobes: reg0 = 0xFFFFFFFF, then write 0x12345678 with WSTRB = 4'b0101 -> reg0 = 0xFF34FF78.
- Backpressure: hold BREADY = 0 for 5 cycles -> BVALID stays high, AWREADY/WREADY stay low, and a second AW is not accepted until B completes.
- Out of range, addr 0x10:
  - With SENSOR_AXIL_SLVERR_EN: BRESP = RRESP = 2'b10, RDATA = 0, regs unchanged.
  - Without it: the access aliases to reg0.
- Reset mid-write: assert S_AXI_ARESET after the AW handshake but before W -> all regs = 0, no BVALID, and the next full write completes normally.

Source files
------------

// File: rtl/sensor_axil_pkg.sv
// Shared constants and helpers for the sensor AXI4-Lite register file.
package sensor_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [31:0] word_t;

   // One captured W beat: data plus its byte enables.
   typedef struct packed {
      word_t      data;
      logic [3:0] strb;
   } wbeat_t;

   function automatic word_t strb_merge(input word_t old_word, input word_t new_word,
                                        input logic [3:0] strb);
      word_t m;
      for (int b = 0; b < 4; b++)
         m[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      return m;
   endfunction

endpackage

// File: rtl/sensor_axil_regs_if.sv
// AXI4-Lite bus bundle between the sensor register file and its master.
interface sensor_axil_regs_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/sensor_axil_wr_slot.sv
// One-entry holding register for a write-channel beat (AW or W).
module sensor_axil_wr_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         full,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         q    <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
         q    <= d;
      end
   end

endmodule

// File: rtl/sensor_axil_regs.sv
// AXI4-Lite register file for the sensor core. Define SENSOR_AXIL_SLVERR_EN to
// answer out-of-range word indices with SLVERR instead of aliasing them.
module sensor_axil_regs
   import sensor_axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_REGS   = 4
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESET,
   sensor_axil_regs_if.slave              s00_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int WORD_W = ADDR_WIDTH - 2;
   typedef logic [IDX_W-1:0] idx_t;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

   logic                  aw_full, w_full, aw_hs, w_hs, commit;
   logic [ADDR_WIDTH-1:0] aw_q, aw_addr_c;
   wbeat_t                w_q, w_in, w_c;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [WORD_W-1:0]     wr_word, rd_word;
   idx_t                  wr_idx, rd_idx;
   logic                  wr_ok, rd_ok, wr_en;
   logic                  ar_hs, rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   // Ready is forced low by reset itself so it rises in the first cycle after release.
   assign s00_axi.awready = !S_AXI_ARESET && !aw_full && !bvalid_q;
   assign s00_axi.wready  = !S_AXI_ARESET && !w_full && !bvalid_q;
   assign s00_axi.arready = !S_AXI_ARESET && !rvalid_q;

   assign aw_hs = s00_axi.awvalid && s00_axi.awready;
   assign w_hs  = s00_axi.wvalid && s00_axi.wready;
   assign w_in  = '{data: s00_axi.wdata, strb: s00_axi.wstrb};

   // A beat arriving in the commit cycle bypasses its slot.
   assign commit    = (aw_full || aw_hs) && (w_full || w_hs);
   assign aw_addr_c = aw_full ? aw_q : s00_axi.awaddr;
   assign w_c       = w_full ? w_q : w_in;

   sensor_axil_wr_slot #(.W(ADDR_WIDTH)) u_aw_slot (
      .clk(S_AXI_ACLK), .rst(S_AXI_ARESET),
      .load(aw_hs && !commit), .clear(commit),
      .d(s00_axi.awaddr), .full(aw_full), .q(aw_q)
   );

   sensor_axil_wr_slot #(.W($bits(wbeat_t))) u_w_slot (
      .clk(S_AXI_ACLK), .rst(S_AXI_ARESET),
      .load(w_hs && !commit), .clear(commit),
      .d(w_in), .full(w_full), .q(w_q)
   );

   assign wr_word = aw_addr_c[ADDR_WIDTH-1:2];
   assign rd_word = s00_axi.araddr[ADDR_WIDTH-1:2];
   assign wr_idx  = idx_t'(32'(wr_word) % NUM_REGS);
   assign rd_idx  = idx_t'(32'(rd_word) % NUM_REGS);

`ifdef SENSOR_AXIL_SLVERR_EN
   assign wr_ok = 32'(wr_word) < NUM_REGS;
   assign rd_ok = 32'(rd_word) < NUM_REGS;
`else
   assign wr_ok = 1'b1;
   assign rd_ok = 1'b1;
`endif

   assign wr_en = commit && wr_ok && (|w_c.strb);

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         regs         <= '0;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (wr_en) begin
            regs[wr_idx]         <= strb_merge(regs[wr_idx], w_c.data, w_c.strb);
            reg_wr_pulse[wr_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else if (commit) begin
         bvalid_q <= 1'b1;
         bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi.bready) begin
         bvalid_q <= 1'b0;
      end
   end

   // Read samples regs before any same-cycle write lands, so it sees the old value.
   assign ar_hs = s00_axi.arvalid && s00_axi.arready;

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_ok ? regs[rd_idx] : '0;
         rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign s00_axi.bvalid = bvalid_q;
   assign s00_axi.bresp  = bresp_q;
   assign s00_axi.rvalid = rvalid_q;
   assign s00_axi.rdata  = rdata_q;
   assign s00_axi.rresp  = rresp_q;
   assign reg_q          = regs;

   logic unused_ok;
   assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, aw_addr_c[1:0], s00_axi.araddr[1:0]};

endmodule

// File: tb/tb_sensor_axil_regs.sv
// Directed bench for sensor_axil_regs: handshakes, strobes, backpressure, range, reset.
module tb_sensor_axil_regs;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sensor_axil_regs_if ax ();
   logic [127:0] reg_q;
   logic [3:0]   reg_wr_pulse;

   sensor_axil_regs dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s00_axi      (ax),
      .reg_q        (reg_q),
      .reg_wr_pulse (reg_wr_pulse)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er, input logic [3:0] ep);
      bit aw_done = 0;
      bit w_done  = 0;
      bit aw_hs, w_hs;
      int n = 0;
      ax.awaddr = a; ax.awvalid = 1'b1;
      ax.wdata = d;  ax.wstrb = s; ax.wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = ax.awvalid && ax.awready;
         w_hs  = ax.wvalid && ax.wready;
         tick();
         n++;
         if (aw_hs) begin aw_done = 1; ax.awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1; ax.wvalid  = 1'b0; end
      end
      ax.awvalid = 1'b0; ax.wvalid = 1'b0;
      chk({tag, "_hs"}, 128'(aw_done && w_done), 128'(1));
      chk({tag, "_bvalid"}, 128'(ax.bvalid), 128'(1));
      chk({tag, "_bresp"}, 128'(ax.bresp), 128'(er));
      chk({tag, "_pulse"}, 128'(reg_wr_pulse), 128'(ep));
      tick();
      chk({tag, "_bclr"}, 128'(ax.bvalid), 128'(0));
   endtask

   task automatic axi_read(input string tag, input logic [5:0] a, input logic [31:0] ed,
                           input logic [1:0] er);
      int n = 0;
      ax.araddr = a; ax.arvalid = 1'b1;
      while (!ax.arready && n < 20) begin tick(); n++; end
      chk({tag, "_arready"}, 128'(ax.arready), 128'(1));
      tick();
      ax.arvalid = 1'b0;
      chk({tag, "_rvalid"}, 128'(ax.rvalid), 128'(1));
      chk({tag, "_rdata"}, 128'(ax.rdata), 128'(ed));
      chk({tag, "_rresp"}, 128'(ax.rresp), 128'(er));
      tick();
      chk({tag, "_rclr"}, 128'(ax.rvalid), 128'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ax.awaddr = '0; ax.awprot = '0; ax.awvalid = 1'b0;
      ax.wdata = '0;  ax.wstrb = '0;  ax.wvalid = 1'b0;
      ax.bready = 1'b1;
      ax.araddr = '0; ax.arprot = 3'b101; ax.arvalid = 1'b0;
      ax.rready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 128'(ax.awready), 128'(0));
      chk("rst_wready",  128'(ax.wready),  128'(0));
      chk("rst_arready", 128'(ax.arready), 128'(0));
      chk("rst_bvalid",  128'(ax.bvalid),  128'(0));
      chk("rst_rvalid",  128'(ax.rvalid),  128'(0));
      chk("rst_resp",    128'({ax.bresp, ax.rresp}), 128'(0));
      chk("rst_rdata",   128'(ax.rdata),   128'(0));
      chk("rst_regs",    reg_q,            128'(0));
      chk("rst_pulse",   128'(reg_wr_pulse), 128'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_awready", 128'(ax.awready), 128'(1));
      chk("post_rst_wready",  128'(ax.wready),  128'(1));
      chk("post_rst_arready", 128'(ax.arready), 128'(1));
      tick();

      // Sequential write then read back
      for (int i = 0; i < 4; i++)
         axi_write($sformatf("seq_w%0d", i), 6'(i*4), 32'(i+1), 4'hF, 2'b00, 4'(1 << i));
      chk("seq_regs", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});
      for (int i = 0; i < 4; i++)
         axi_read($sformatf("seq_r%0d", i), 6'(i*4), 32'(i+1), 2'b00);

      // W arrives well ahead of AW
      ax.wdata = 32'hDEADBEEF; ax.wstrb = 4'hF; ax.wvalid = 1'b1;
      chk("skew_wready_pre", 128'(ax.wready), 128'(1));
      tick();
      ax.wvalid = 1'b0;
      chk("skew_wready", 128'(ax.wready), 128'(0));
      chk("skew_bvalid_early", 128'(ax.bvalid), 128'(0));
      tick();
      tick();
      ax.awaddr = 6'h04; ax.awvalid = 1'b1;
      chk("skew_awready", 128'(ax.awready), 128'(1));
      tick();
      ax.awvalid = 1'b0;
      chk("skew_bvalid", 128'(ax.bvalid), 128'(1));
      chk("skew_reg1", 128'(reg_q[63:32]), 128'(32'hDEADBEEF));
      chk("skew_pulse", 128'(reg_wr_pulse), 128'(4'b0010));
      tick();
      chk("skew_bclr", 128'(ax.bvalid), 128'(0));

      // Byte strobes
      axi_write("strb_ff", 6'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 4'b0001);
      axi_write("strb_0101", 6'h00, 32'h12345678, 4'b0101, 2'b00, 4'b0001);
      chk("strb_reg0", 128'(reg_q[31:0]), 128'(32'hFF34FF78));
      axi_write("strb_zero", 6'h04, 32'h0, 4'h0, 2'b00, 4'b0000);
      chk("strb_zero_reg1", 128'(reg_q[63:32]), 128'(32'hDEADBEEF));

      // Backpressure on B, second AW waiting
      ax.bready = 1'b0;
      ax.awaddr = 6'h08; ax.awvalid = 1'b1;
      ax.wdata = 32'hAA; ax.wstrb = 4'hF; ax.wvalid = 1'b1;
      tick();
      ax.wvalid = 1'b0;
      ax.awaddr = 6'h0C;
      chk("bp_reg2", 128'(reg_q[95:64]), 128'(32'hAA));
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_bvalid%0d", i),  128'(ax.bvalid),  128'(1));
         chk($sformatf("bp_awready%0d", i), 128'(ax.awready), 128'(0));
         chk($sformatf("bp_wready%0d", i),  128'(ax.wready),  128'(0));
         tick();
      end
      chk("bp_reg3_hold", 128'(reg_q[127:96]), 128'(32'h4));
      ax.bready = 1'b1;
      tick();
      chk("bp_bclr", 128'(ax.bvalid), 128'(0));
      chk("bp_awready_after", 128'(ax.awready), 128'(1));
      ax.wdata = 32'h55; ax.wvalid = 1'b1;
      tick();
      ax.awvalid = 1'b0; ax.wvalid = 1'b0;
      chk("bp2_bvalid", 128'(ax.bvalid), 128'(1));
      chk("bp2_reg3", 128'(reg_q[127:96]), 128'(32'h55));
      chk("bp2_pulse", 128'(reg_wr_pulse), 128'(4'b1000));
      tick();
      chk("bp2_bclr", 128'(ax.bvalid), 128'(0));

      // Word index beyond the register file
`ifdef SENSOR_AXIL_SLVERR_EN
      axi_write("oor_w", 6'h10, 32'h77, 4'hF, 2'b10, 4'b0000);
      chk("oor_regs", reg_q, {32'h55, 32'hAA, 32'hDEADBEEF, 32'hFF34FF78});
      axi_read("oor_r", 6'h10, 32'h0, 2'b10);
`else
      axi_write("alias_w", 6'h10, 32'h77, 4'hF, 2'b00, 4'b0001);
      chk("alias_regs", reg_q, {32'h55, 32'hAA, 32'hDEADBEEF, 32'h77});
      axi_read("alias_r", 6'h10, 32'h77, 2'b00);
`endif

      // Reset between AW and W
      ax.awaddr = 6'h04; ax.awvalid = 1'b1;
      tick();
      ax.awvalid = 1'b0;
      chk("mid_aw_held", 128'(ax.awready), 128'(0));
      rst = 1'b1;
      #1;
      chk("mid_regs", reg_q, 128'(0));
      chk("mid_bvalid", 128'(ax.bvalid), 128'(0));
      chk("mid_awready", 128'(ax.awready), 128'(0));
      tick();
      rst = 1'b0;
      tick();
      chk("mid_idle_bvalid", 128'(ax.bvalid), 128'(0));
      chk("mid_slot_dropped", 128'(ax.awready), 128'(1));
      axi_write("mid_w", 6'h0C, 32'h99, 4'hF, 2'b00, 4'b1000);
      chk("mid_regs_after", reg_q, {32'h99, 32'h0, 32'h0, 32'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
